// File: rtl/usb_setup_decoder.sv
// rtl/usb_setup_decoder.sv - endpoint-0 SETUP token/DATA0 decoder with CRC16 check
//
// Purpose: match a SETUP token for this device/endpoint, capture the following
// 8-byte DATA0 request plus CRC16, and publish the standard request fields
// with a one-cycle setup_valid (good request) or setup_err (dropped request).
//
// Ports:
//   USB_CLKIN        clock, all logic on its rising edge
//   RST              asynchronous active-high reset
//   dev_addr         current device address
//   token_0/_strb    received token {crc5, ep, addr, pid} and its one-cycle strobe
//   pid_o            PID of the data packet in progress
//   data_o_0/_strb_0 received data byte stream (CRC16 bytes included)
//   data_o_end_0     clean end of packet pulse
//   data_o_fail_0    aborted packet pulse
//   bm_request_type, b_request, w_value, w_index, w_length  decoded request fields
//   setup_valid      one-cycle pulse: new request on the field outputs
//   setup_err        one-cycle pulse: a matched SETUP transaction was dropped

module usb_setup_decoder #(
    parameter int EP_NUM  = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic        USB_CLKIN,
    input  logic        RST,
    input  logic [6:0]  dev_addr,
    input  logic [23:0] token_0,
    input  logic        token_0_strb,
    input  logic [7:0]  pid_o,
    input  logic [7:0]  data_o_0,
    input  logic        data_o_strb_0,
    input  logic        data_o_end_0,
    input  logic        data_o_fail_0,
    output logic [7:0]  bm_request_type,
    output logic [7:0]  b_request,
    output logic [15:0] w_value,
    output logic [15:0] w_index,
    output logic [15:0] w_length,
    output logic        setup_valid,
    output logic        setup_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RECV  = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    localparam logic [7:0]  PID_SETUP  = 8'h2D;
    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;
    // Register contents after running data plus the transmitted CRC16 bytes.
    localparam logic [15:0] CRC_RESID  = 16'hB001;
    localparam logic [3:0]  EP_BITS    = EP_NUM[3:0];
    localparam int          TW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [15:0]   crc_q, crc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [63:0]   shadow_q, shadow_d;
    logic [63:0]   fields_q, fields_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic          setup_hit;
    logic [15:0]   crc_next;
    logic [3:0]    cnt_next;
    logic [63:0]   shadow_next;
    logic          crc5_unused;

    // Reflected CRC16 (poly 0x8005 -> 0xA001), data bits consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // CRC5 of the token is not checked here; the multiplexer already filtered it.
    assign crc5_unused = ^token_0[23:19];

    assign setup_hit = token_0_strb
                    && (token_0[7:0]   == PID_SETUP)
                    && (token_0[14:8]  == dev_addr)
                    && (token_0[18:15] == EP_BITS);

    // Effect of absorbing the current byte; used by both WAIT_DATA and RECV.
    always_comb begin
        crc_next    = crc16_byte(crc_q, data_o_0);
        cnt_next    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        shadow_next = shadow_q;
        if (cnt_q < 4'd8) begin
            shadow_next[{cnt_q[2:0], 3'b000} +: 8] = data_o_0;
        end
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        fields_d = fields_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (setup_hit) begin
            // A matching SETUP wins in every state and silently restarts capture.
            state_d = ST_WAIT;
            crc_d   = CRC_INIT;
            cnt_d   = 4'd0;
            tmo_d   = TMO_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_WAIT: begin
                    if (token_0_strb) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (data_o_strb_0) begin
                        if (pid_o == PID_DATA0) begin
                            crc_d    = crc_next;
                            cnt_d    = cnt_next;
                            shadow_d = shadow_next;
                            if (data_o_fail_0) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end else if (data_o_end_0) begin
                                state_d = ST_CHECK;
                            end else begin
                                state_d = ST_RECV;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (tmo_q <= TW'(1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q - TW'(1);
                    end
                end
                ST_RECV: begin
                    if (data_o_strb_0) begin
                        crc_d    = crc_next;
                        cnt_d    = cnt_next;
                        shadow_d = shadow_next;
                    end
                    // The byte of this cycle is absorbed before end/fail is acted on.
                    if (data_o_fail_0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (data_o_end_0) begin
                        state_d = ST_CHECK;
                    end
                end
                default: begin
                    if ((cnt_q == 4'd10) && (crc_q == CRC_RESID)) begin
                        fields_d = shadow_q;
                        valid_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge USB_CLKIN or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            crc_q    <= CRC_INIT;
            cnt_q    <= 4'd0;
            tmo_q    <= '0;
            shadow_q <= 64'd0;
            fields_q <= 64'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            fields_q <= fields_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign bm_request_type = fields_q[7:0];
    assign b_request       = fields_q[15:8];
    assign w_value         = fields_q[31:16];
    assign w_index         = fields_q[47:32];
    assign w_length        = fields_q[63:48];
    assign setup_valid     = valid_q;
    assign setup_err       = err_q;

endmodule

// File: doc/usb_setup_decoder.md
# usb_setup_decoder

Endpoint-0 SETUP transaction decoder sitting directly downstream of `usb_handshake_multiplexer`. It consumes the multiplexer's received-token strobe and the received-data byte stream, and matches a SETUP token addressed to this device and endpoint. It captures the following 8-byte DATA0 payload, verifies its CRC16 and presents the decoded standard request fields with a single-cycle valid or error pulse. Its outputs drive the control-endpoint request handler and the handshake (ACK) generator.

## Interface
Parameters:
- `EP_NUM`, 0: endpoint number that SETUP tokens must carry.
- `TIMEOUT`, 1024: cycles allowed between an accepted SETUP token and the first data byte.

Ports:
- `USB_CLKIN`  in  1  60 MHz ULPI clock. One clock domain; everything is sampled on its rising edge.
- `RST`  in  1  Reset. Reset is asynchronous and active-high.
- `dev_addr`  in  7  Current device address (0 before SET_ADDRESS).
- `token_0`  in  24  Received token: [7:0] PID, [14:8] address, [18:15] endpoint, [23:19] CRC5.
- `token_0_strb`  in  1  One-cycle pulse; `token_0` is valid in that cycle.
- `pid_o`  in  8  PID of the data packet in progress; valid while `data_o_strb_0` is high.
- `data_o_0`  in  8  Received data byte; valid while `data_o_strb_0` is high.
- `data_o_strb_0`  in  1  One byte per high cycle. The CRC16 bytes are included as the last two bytes.
- `data_o_end_0`  in  1  One-cycle pulse marking a clean end of packet.
- `data_o_fail_0`  in  1  One-cycle pulse marking an aborted packet.
- `bm_request_type`  out  8  Decoded request byte 0.
- `b_request`  out  8  Decoded request byte 1.
- `w_value`  out  16  Decoded request bytes 3:2, little-endian.
- `w_index`  out  16  Decoded request bytes 5:4, little-endian.
- `w_length`  out  16  Decoded request bytes 7:6, little-endian.
- `setup_valid`  out  1  One-cycle pulse: a new request is on the field outputs.
- `setup_err`  out  1  One-cycle pulse: a matched SETUP transaction was dropped.

## Operation
- **States:** IDLE, WAIT_DATA, RECV, CHECK.
- **IDLE:**
  - Go to WAIT_DATA on `token_0_strb` with PID = 0x2D, address = `dev_addr` and endpoint = `EP_NUM`.
  - Any other token is ignored. CRC5 is not checked here.
- **WAIT_DATA:**
  - Clear the byte counter, load the CRC register with 0xFFFF and load the timeout counter with `TIMEOUT`.
  - The first `data_o_strb_0` with `pid_o` = 0xC3 (DATA0) moves to RECV and processes that byte.
  - Any other PID on the first byte → `setup_err`, go to IDLE.
  - Another `token_0_strb`:
    - A matching SETUP restarts WAIT_DATA.
    - Any other token → `setup_err`, go to IDLE.
  - Timeout counter reaching 0 → `setup_err`, go to IDLE.
- **RECV:**
  - Each strobe shifts the byte into the CRC16 register (polynomial 0x8005, reflected, LSB first) and increments a 4-bit saturating counter.
  - Bytes 0–7 are stored into a shadow register. Bytes beyond index 9 are counted but not stored.
  - `data_o_end_0` → CHECK.
  - `data_o_fail_0` → `setup_err`, go to IDLE, shadow discarded.
  - A matching SETUP token restarts WAIT_DATA with no error pulse.
- **CHECK** (one cycle):
  - Pass requires count == 10 and CRC register == 0xB001 (the reflected 0x800D residual).
  - Pass: copy the shadow to the field outputs, pulse `setup_valid`, go to IDLE.
  - Fail: pulse `setup_err`, field outputs unchanged, go to IDLE.
- Field outputs change only on a `setup_valid` cycle and hold until the next one.
- A SETUP always overrides a pending request; no back-pressure exists.

## Timing
- **Reset:** all field outputs 0, `setup_valid` = 0, `setup_err` = 0, state IDLE, CRC register 0xFFFF, counters 0.
- **Mid-packet reset:** assertion aborts immediately with no pulse. After deassertion, the next `data_o_0` bytes are ignored until a new SETUP token.
- **Byte capture:** a byte is captured on the same rising edge at which its strobe is sampled.
- **End of packet:** `data_o_end_0` sampled at edge N → CHECK during cycle N+1 → `setup_valid`/`setup_err` high during cycle N+2, with the fields already updated.
- **Simultaneous events:**
  - `data_o_strb_0` together with `data_o_end_0`: the byte is processed first, then the end is honoured.
  - `data_o_fail_0` takes priority over `data_o_end_0`.
  - `token_0_strb` takes priority over the data inputs.
- **Timeout:** `TIMEOUT` = 1024 gives `setup_err` exactly 1024 cycles after the token edge if no byte arrives.
- **Pulse exclusivity:** `setup_valid` and `setup_err` are never high together and are never high for more than one cycle.

## Test plan
- **Valid GET_DESCRIPTOR.** `dev_addr` = 0. SETUP token 0x2D, address 0, endpoint 0. Then DATA0 bytes 80 06 00 01 00 00 40 00 DD 94 and end.
  - Required: `setup_valid` 2 cycles after end.
  - Required fields: `bm_request_type` = 0x80, `b_request` = 0x06, `w_value` = 0x0100, `w_index` = 0, `w_length` = 0x0040.
- **Address mismatch.** `dev_addr` = 5, token address 0, same payload.
  - Required: no pulse at all; fields keep their previous values.
- **Corrupt CRC.** Same payload with the last byte changed to 0x95.
  - Required: `setup_err` pulse; fields unchanged from the previous valid request.
- **Wrong length or wrong PID.** Nine-byte payload, and separately PID 0x4B (DATA1).
  - Required: one `setup_err` each.
- **Abort, timeout and restart.** Three cases:
  - `data_o_fail_0` after 4 bytes → `setup_err`.
  - No data for 1024 cycles after the token → `setup_err` at cycle 1024.
  - A second SETUP mid-payload, followed by a complete valid packet → a single `setup_valid`.
- **Reset mid-RECV.** Assert `RST` after byte 3, then release.
  - Required: all outputs 0, with no pulse during or after reset.
  - Required: remaining bytes ignored; the next full transaction decodes correctly.
